// File: rtl/shift_ser_pkg.sv
// shift_ser_pkg -- shared types and sizing helpers for the shift_ser serializer.
// Optional feature macro: SHIFT_SER_PARITY_EN (adds the PAR state).
package shift_ser_pkg;

  // FSM state encoding. PAR only exists when the parity bit is appended.
`ifdef SHIFT_SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  // Width of the state vector as seen on the debug port.
  localparam int STATE_W = 2;

  // Default parameter values of the serializer.
  localparam int DW_DEFAULT        = 8;
  localparam int DIV_DEFAULT       = 1;
  localparam int MSB_FIRST_DEFAULT = 0;

  // Counter width able to hold the value n without overflow: clog2(n+1).
  // Always at least one bit for any n >= 1.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage : shift_ser_pkg

// File: rtl/shift_ser_div.sv
// shift_ser_div -- bit-period divider for shift_ser.
// Counts 0..DIV-1 while running and raises tick in the last cycle of each
// serial bit. clear restarts the count at zero on the frame accept edge.
module shift_ser_div
  import shift_ser_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Bit boundary: last of the DIV cycles that one serial bit is held.
  assign tick = run && (cnt == LAST);

  // Divide counter: wraps to zero at each bit boundary, idles at zero.
  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      cnt <= '0;
    end else if (run) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + CW'(1);
    end
  end

endmodule : shift_ser_div

// File: rtl/shift_ser.sv
// shift_ser -- parallel-to-serial shifter with valid/ready input side.
//
// Handshake: a word is taken on a rising edge where in_valid and in_ready are
// both 1. in_ready is 1 only in IDLE; while it is 0, in_valid and in_data are
// ignored. ser_valid marks every cycle that carries a frame bit, and
// frame_end pulses during the final cycle of the final frame bit.
//
// Optional feature macro: SHIFT_SER_PARITY_EN appends one even-parity bit
// (state PAR) after the data bits; frame_end then marks the parity bit.
//
// dbg_state exposes the FSM state for checkers.
module shift_ser
  import shift_ser_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int MSB_FIRST = MSB_FIRST_DEFAULT,
  parameter int DIV       = DIV_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               frame_end,
  output logic [STATE_W-1:0] dbg_state
);

  localparam int BW = cnt_w(DW);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  state_t        state;
  logic [DW-1:0] shreg;
  logic [DW-1:0] shreg_next;
  logic [BW-1:0] bit_cnt;
  logic          accept;
  logic          run;
  logic          tick;
  logic          out_bit;
  logic          last_data;
`ifdef SHIFT_SER_PARITY_EN
  logic          parity;
`endif

  // A word is only taken in IDLE; reset wins over accept inside the FSM.
  assign accept = in_valid && (state == IDLE);
  assign run    = (state != IDLE);

  // Bit-period divider; restarted on every accept.
  shift_ser_div #(
    .DIV (DIV)
  ) u_div (
    .Clk   (Clk),
    .Rst   (Rst),
    .clear (accept),
    .run   (run),
    .tick  (tick)
  );

  // Data bit currently presented and the register value after one shift.
  // The shift always moves toward the output end with zero fill.
  always_comb begin
    if (MSB_FIRST != 0) begin
      out_bit    = shreg[DW-1];
      shreg_next = {shreg[DW-2:0], 1'b0};
    end else begin
      out_bit    = shreg[0];
      shreg_next = {1'b0, shreg[DW-1:1]};
    end
  end

  // Last cycle of the last data bit.
  assign last_data = (state == SHIFT) && (bit_cnt == LAST_BIT) && tick;

  // Frame sequencing: load on accept, shift at each bit boundary, finish
  // after the last data bit (or the parity bit).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef SHIFT_SER_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= in_data;
            bit_cnt <= '0;
`ifdef SHIFT_SER_PARITY_EN
            parity  <= 1'b0;
`endif
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            shreg <= shreg_next;
`ifdef SHIFT_SER_PARITY_EN
            // Accumulate each data bit as it completes; after the last one
            // the accumulator holds the XOR of all DW bits.
            parity <= parity ^ out_bit;
`endif
            if (last_data) begin
              bit_cnt <= '0;
`ifdef SHIFT_SER_PARITY_EN
              state   <= PAR;
`else
              state   <= IDLE;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
`ifdef SHIFT_SER_PARITY_EN
        PAR: begin
          if (tick) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only (no input-to-output path).
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = out_bit;
`ifndef SHIFT_SER_PARITY_EN
        frame_end = last_data;
`endif
      end
`ifdef SHIFT_SER_PARITY_EN
      PAR: begin
        ser_valid = 1'b1;
        ser_out   = parity;
        frame_end = tick;
      end
`endif
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign dbg_state = state;

endmodule : shift_ser

// File: tb/tb_shift_ser.sv
// tb_shift_ser -- bench for shift_ser with three configurations:
//   u0: DW=8 MSB_FIRST=0 DIV=1, u1: DW=8 MSB_FIRST=1 DIV=1,
//   u2: DW=8 MSB_FIRST=0 DIV=3.
// Build with SHIFT_SER_PARITY_EN defined to exercise the parity bit.
module tb_shift_ser;

  logic       Clk;
  logic       Rst;
  logic [7:0] id  [3];
  logic       iv  [3];
  logic       rdy [3];
  logic       so  [3];
  logic       sv  [3];
  logic       fe  [3];
  logic [1:0] ds  [3];

  // Expected {ser_out, frame_end} per serial cycle, one queue per instance.
  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];
  logic [1:0] exp_q2[$];

  int  checks = 0;
  int  errors = 0;
  bit  in_frame [3];
  bit  prev_fe  [3];

  // ---------------------------------------------------------------- clock/reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  shift_ser #(.DW(8), .MSB_FIRST(0), .DIV(1)) u0 (
    .Clk(Clk), .Rst(Rst), .in_data(id[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .frame_end(fe[0]), .dbg_state(ds[0]));
  shift_ser #(.DW(8), .MSB_FIRST(1), .DIV(1)) u1 (
    .Clk(Clk), .Rst(Rst), .in_data(id[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .frame_end(fe[1]), .dbg_state(ds[1]));
  shift_ser #(.DW(8), .MSB_FIRST(0), .DIV(3)) u2 (
    .Clk(Clk), .Rst(Rst), .in_data(id[2]), .in_valid(iv[2]), .in_ready(rdy[2]),
    .ser_out(so[2]), .ser_valid(sv[2]), .frame_end(fe[2]), .dbg_state(ds[2]));

  // ---------------------------------------------------------------- queue helpers
  task automatic q_push(input int i, input logic [1:0] v);
    case (i)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [1:0] q_pop(input int i);
    case (i)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  // Expected serial stream of one frame: bit order from MSB_FIRST, each bit
  // held DIV cycles, frame_end on the final cycle of the final bit.
  task automatic push_frame(input int i, input logic [7:0] w);
    int   div;
    int   nbits;
    logic b;
    div   = (i == 2) ? 3 : 1;
`ifdef SHIFT_SER_PARITY_EN
    nbits = 9;
`else
    nbits = 8;
`endif
    for (int k = 0; k < nbits; k++) begin
      if (k == 8)      b = ^w;
      else if (i == 1) b = w[7-k];
      else             b = w[k];
      for (int d = 0; d < div; d++)
        q_push(i, {b, (k == nbits - 1) && (d == div - 1)});
    end
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic mon(input int i);
    logic [1:0] e;
    if (prev_fe[i]) begin
      checks++;
      if (rdy[i] !== 1'b1 || sv[i] !== 1'b0) begin
        errors++;
        $display("FAIL ready_after_end u%0d: in_ready=%0b ser_valid=%0b, required 1 0",
                 i, rdy[i], sv[i]);
      end
    end
    if (sv[i] === 1'b1) begin
      checks++;
      if (q_size(i) == 0) begin
        errors++;
        $display("FAIL unexpected_bit u%0d: ser_out=%0b frame_end=%0b with nothing expected",
                 i, so[i], fe[i]);
      end else begin
        e = q_pop(i);
        if ({so[i], fe[i]} !== e) begin
          errors++;
          $display("FAIL serial_bit u%0d: ser_out=%0b frame_end=%0b, required %0b %0b",
                   i, so[i], fe[i], e[1], e[0]);
        end
      end
      checks++;
      if (rdy[i] !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready u%0d: in_ready=%0b, required 0", i, rdy[i]);
      end
    end else begin
      checks++;
      if (in_frame[i] || fe[i] !== 1'b0 || so[i] !== 1'b0 || rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL idle_outputs u%0d: gap=%0b frame_end=%0b ser_out=%0b in_ready=%0b, required 0 0 0 1",
                 i, in_frame[i], fe[i], so[i], rdy[i]);
      end
    end
    in_frame[i] = (sv[i] === 1'b1) && (fe[i] !== 1'b1);
    prev_fe[i]  = (sv[i] === 1'b1) && (fe[i] === 1'b1);
    if (Rst) begin
      in_frame[i] = 1'b0;
      prev_fe[i]  = 1'b0;
    end
  endtask

  always @(negedge Clk) begin
    for (int i = 0; i < 3; i++) mon(i);
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic wait_ready(input int i);
    int n;
    n = 0;
    @(negedge Clk);
    while (rdy[i] !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (rdy[i] !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout u%0d: in_ready=%0b after %0d cycles, required 1", i, rdy[i], n);
    end
  endtask

  task automatic check_latency(input int i);
    @(negedge Clk);
    checks++;
    if (sv[i] !== 1'b1) begin
      errors++;
      $display("FAIL first_bit_latency u%0d: ser_valid=%0b after accept, required 1", i, sv[i]);
    end
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (!(q_size(i) == 0 && rdy[i] === 1'b1) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (q_size(i) != 0) begin
      errors++;
      $display("FAIL frame_timeout u%0d: %0d bits still expected, required 0", i, q_size(i));
    end
  endtask

  task automatic send(input int i, input logic [7:0] w);
    push_frame(i, w);
    wait_ready(i);
    iv[i] = 1'b1;
    id[i] = w;
    @(posedge Clk);
    #1;
    iv[i] = 1'b0;
    check_latency(i);
    wait_done(i);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      id[i] = 8'h00;
    end
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Reset values of every output.
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b1 || sv[i] !== 1'b0 || so[i] !== 1'b0 || fe[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs u%0d: ready=%0b valid=%0b out=%0b end=%0b, required 1 0 0 0",
                 i, rdy[i], sv[i], so[i], fe[i]);
      end
    end

    // LSB first, DIV=1: 0x0F -> 1,1,1,1,0,0,0,0.
    send(0, 8'h0F);
    send(0, 8'hA5);
    send(0, 8'h07);
    send(0, 8'h03);
    send(0, 8'h00);
    // MSB first: 0x0F -> 0,0,0,0,1,1,1,1.
    send(1, 8'h0F);
    send(1, 8'h81);
    // DIV=3: 0x01 -> 1 for 3 cycles then 0 for 21 cycles.
    send(2, 8'h01);
    send(2, 8'hC6);

    // Reset during the 4th bit of a frame: bits 0..3 of 0x3C appear, then abort.
    push_frame(0, 8'h3C);
    begin
      logic [1:0] keep [$];
      for (int k = 0; k < 4; k++) keep.push_back(exp_q0[k]);
      exp_q0 = keep;
    end
    wait_ready(0);
    iv[0] = 1'b1;
    id[0] = 8'h3C;
    @(posedge Clk);
    #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (rdy[0] !== 1'b1 || sv[0] !== 1'b0 || fe[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_reset: ready=%0b valid=%0b end=%0b, required 1 0 0",
               rdy[0], sv[0], fe[0]);
    end
    send(0, 8'hF0);

    // Reset has priority over an accept on the same edge.
    wait_ready(0);
    Rst   = 1'b1;
    iv[0] = 1'b1;
    id[0] = 8'hFF;
    @(posedge Clk);
    #1;
    Rst   = 1'b0;
    iv[0] = 1'b0;
    @(negedge Clk);
    checks++;
    if (sv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_priority: ser_valid=%0b in_ready=%0b, required 0 1", sv[0], rdy[0]);
    end

    // Back-to-back: in_valid held high; junk data while busy must be ignored.
    push_frame(0, 8'h55);
    push_frame(0, 8'hAA);
    wait_ready(0);
    iv[0] = 1'b1;
    id[0] = 8'h55;
    @(posedge Clk);
    #1;
    id[0] = 8'h33;
    wait_ready(0);
    id[0] = 8'hAA;
    @(posedge Clk);
    #1;
    iv[0] = 1'b0;
    check_latency(0);
    wait_done(0);

    repeat (5) @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_size(i) != 0) begin
        errors++;
        $display("FAIL leftover_expected u%0d: %0d entries, required 0", i, q_size(i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_ser
